// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell counter: mode encoding and widths.
package jk_pkg;

    localparam int unsigned JK_MODE_W = 2;

    typedef enum logic [JK_MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } jk_mode_t;

endpackage

// File: rtl/jk_ff_cell.sv
// One-bit JK flip-flop with synchronous active-low clear and clock enable.
// qb is the inverted stored bit, so it can never disagree with q.
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_r;

    // JK truth table: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q  = q_r;
    assign qb = ~q_r;

endmodule

// File: rtl/jk_counter.sv
// Modulo up/down counter with parallel load, built from per-bit JK cells.
// Optional feature macro: JKC_RAW_EN adds j/k/raw_en for direct per-bit JK control.
module jk_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
`ifdef JKC_RAW_EN
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             raw_en,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    jk_mode_t         mode_e;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic [WIDTH-1:0] toggle;
    logic             wrap_nxt;

    assign mode_e = jk_mode_t'(mode);

    // Per-bit J/K drive: toggle masks for counting, set/clear patterns for constants and loads
    always_comb begin
        j_vec    = '0;
        k_vec    = '0;
        toggle   = '0;
        wrap_nxt = 1'b0;
        case (mode_e)
            MODE_UP: begin
                if (q >= MAX_VAL) begin
                    k_vec    = '1;
                    wrap_nxt = 1'b1;
                end else begin
                    toggle = q ^ (q + WIDTH'(1));
                    j_vec  = toggle;
                    k_vec  = toggle;
                end
            end
            MODE_DOWN: begin
                if (q == '0) begin
                    j_vec    = MAX_VAL;
                    k_vec    = ~MAX_VAL;
                    wrap_nxt = 1'b1;
                end else begin
                    toggle = q ^ (q - WIDTH'(1));
                    j_vec  = toggle;
                    k_vec  = toggle;
                end
            end
            MODE_LOAD: begin
                j_vec = d;
                k_vec = ~d;
            end
            default: begin
                j_vec = '0;
                k_vec = '0;
            end
        endcase
`ifdef JKC_RAW_EN
        if (raw_en) begin
            j_vec    = j;
            k_vec    = k;
            wrap_nxt = 1'b0;
        end
`endif
    end

    // Bit cells; en gates every cell so a disabled counter holds its value
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q[i]),
            .qb    (qb[i])
        );
    end

    // Wrap pulse: one cycle after a wrapping edge, cleared whenever disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

endmodule
